// File: rtl/alu_regfile.sv
// Register file wrapped around alu32: two combinational read ports, one write port, and a
// registered copy of the ALU status flags. r0 reads as zero; optional write-to-read bypass.
module alu_regfile #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1,
  localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_num,
  input  logic [ADDR_W-1:0] rt_num,
  output logic [WIDTH-1:0]  rs_data,
  output logic [WIDTH-1:0]  rt_data,
  input  logic [ADDR_W-1:0] rd_num,
  input  logic [WIDTH-1:0]  rd_data,
  input  logic              rd_we,
  input  logic              flag_we,
  input  logic              overflow_in,
  input  logic              zero_in,
  input  logic              negative_in,
  output logic [2:0]        flags_out
);

  localparam logic [ADDR_W:0] NREGS_W = (ADDR_W + 1)'(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [2:0]       flags_q;
  logic [2:0]       flags_d;
  logic             wr_valid;

  // r0 and indices past the last register are never writable nor readable.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  // Holding reset also suppresses the bypass path, so reads show zero immediately.
  assign wr_valid = rd_we && !reset && addr_ok(rd_num);

  // Register storage: cleared asynchronously, written on qualified write enables.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_q[rd_num] <= rd_data;
    end
  end

  // Flag capture selection.
  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d = {overflow_in, zero_in, negative_in};
    end else begin
      flags_d = flags_q;
    end
  end

  // Flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_out = flags_q;

  // Read port S.
  always_comb begin
    rs_data = '0;
    if (BYPASS && wr_valid && (rs_num == rd_num)) begin
      rs_data = rd_data;
    end else if (addr_ok(rs_num)) begin
      rs_data = regs_q[rs_num];
    end else begin
      rs_data = '0;
    end
  end

  // Read port T.
  always_comb begin
    rt_data = '0;
    if (BYPASS && wr_valid && (rt_num == rd_num)) begin
      rt_data = rd_data;
    end else if (addr_ok(rt_num)) begin
      rt_data = regs_q[rt_num];
    end else begin
      rt_data = '0;
    end
  end

endmodule

// File: tb/tb_alu_regfile.sv
// Directed plus randomized bench for alu_regfile; runs a bypassing and a non-bypassing
// instance side by side against a simple array model of the register file.
module tb_alu_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rs_num, rt_num, rd_num;
  logic [31:0] rd_data;
  logic        rd_we, flag_we, overflow_in, zero_in, negative_in;
  logic [31:0] rs_b, rt_b, rs_n, rt_n;
  logic [2:0]  flags_b, flags_n;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] mref [32];
  logic [2:0]  mflags;

  always #5 clock = ~clock;

  alu_regfile #(.WIDTH(32), .NREGS(32), .BYPASS(1'b1)) dut_b (
    .clock(clock), .reset(reset), .rs_num(rs_num), .rt_num(rt_num),
    .rs_data(rs_b), .rt_data(rt_b), .rd_num(rd_num), .rd_data(rd_data),
    .rd_we(rd_we), .flag_we(flag_we), .overflow_in(overflow_in),
    .zero_in(zero_in), .negative_in(negative_in), .flags_out(flags_b));

  alu_regfile #(.WIDTH(32), .NREGS(32), .BYPASS(1'b0)) dut_n (
    .clock(clock), .reset(reset), .rs_num(rs_num), .rt_num(rt_num),
    .rs_data(rs_n), .rt_data(rt_n), .rd_num(rd_num), .rd_data(rd_data),
    .rd_we(rd_we), .flag_we(flag_we), .overflow_in(overflow_in),
    .zero_in(zero_in), .negative_in(negative_in), .flags_out(flags_n));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural read value: r0 is zero, a live write shows through only with bypass.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && !reset && rd_we === 1'b1 && rd_num == a) return rd_data;
    return mref[a];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, " rs bypass"},   rs_b, exp_read(rs_num, 1'b1));
    check({tag, " rt bypass"},   rt_b, exp_read(rt_num, 1'b1));
    check({tag, " rs nobypass"}, rs_n, exp_read(rs_num, 1'b0));
    check({tag, " rt nobypass"}, rt_n, exp_read(rt_num, 1'b0));
  endtask

  task automatic check_flags(input string tag);
    check({tag, " flags bypass"},   {29'd0, flags_b}, {29'd0, mflags});
    check({tag, " flags nobypass"}, {29'd0, flags_n}, {29'd0, mflags});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mref[i] = 32'd0;
    mflags = 3'b000;
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    if (!reset) begin
      if (rd_we === 1'b1 && rd_num != 5'd0) mref[rd_num] = rd_data;
      if (flag_we) mflags = {overflow_in, zero_in, negative_in};
    end
    #1;
    check_flags(tag);
    check_reads({tag, " post"});
  endtask

  task automatic step(input string tag, input logic we, input logic [4:0] rd,
                      input logic [31:0] d, input logic [4:0] rs, input logic [4:0] rt,
                      input logic fwe, input logic [2:0] fl);
    rd_we = we; rd_num = rd; rd_data = d; rs_num = rs; rt_num = rt;
    flag_we = fwe; {overflow_in, zero_in, negative_in} = fl;
    #1;
    check_reads({tag, " pre"});
    tick(tag);
  endtask

  initial begin
    reset = 1'b1;
    rd_we = 1'b0; rd_num = 5'd0; rd_data = 32'd0; rs_num = 5'd0; rt_num = 5'd0;
    flag_we = 1'b0; overflow_in = 1'b0; zero_in = 1'b0; negative_in = 1'b0;
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    check_flags("in reset");
    reset = 1'b0;

    // 1: all registers read zero after reset
    for (int i = 0; i < 32; i++) begin
      rs_num = 5'(i); rt_num = 5'(31 - i);
      #1;
      check_reads("reset scan");
    end
    check_flags("after reset");

    // 2: r3 = 12, then both ports on r3; r0 write dropped
    step("w r3", 1'b1, 5'd3, 32'd12, 5'd3, 5'd3, 1'b0, 3'b000);
    check("r3 direct", rs_b, 32'd12);
    step("rd r3", 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0, 3'b000);
    step("w r0", 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 3'b000);
    check("r0 direct", rs_b, 32'd0);

    // 3: bypass on r5
    rd_we = 1'b1; rd_num = 5'd5; rd_data = 32'hFFFFFFFD; rs_num = 5'd5; rt_num = 5'd3;
    #1;
    check("r5 bypass pre", rs_b, 32'hFFFFFFFD);
    check("r5 nobypass pre", rs_n, 32'd0);
    tick("w r5");
    check("r5 nobypass post", rs_n, 32'hFFFFFFFD);

    // 4: flag capture and hold
    step("flags 101", 1'b0, 5'd0, 32'd0, 5'd5, 5'd3, 1'b1, 3'b101);
    check("flags 101 direct", {29'd0, flags_b}, 32'd5);
    step("flags hold", 1'b0, 5'd0, 32'd0, 5'd5, 5'd3, 1'b0, 3'b010);
    check("flags hold direct", {29'd0, flags_n}, 32'd5);

    // 5: async reset mid-cycle during a write and a capture
    step("w r7", 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b1, 3'b111);
    rd_we = 1'b1; rd_num = 5'd7; rd_data = 32'h12345678; rs_num = 5'd7; rt_num = 5'd7;
    flag_we = 1'b1; {overflow_in, zero_in, negative_in} = 3'b110;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reads("async reset");
    check_flags("async reset");
    tick("reset edge");
    reset = 1'b0;
    rd_we = 1'b0; flag_we = 1'b0;
    #1;
    check_reads("after async reset");

    // 6: r1, r2, r31
    step("w r1", 1'b1, 5'd1, 32'd36, 5'd1, 5'd2, 1'b0, 3'b000);
    step("w r2", 1'b1, 5'd2, 32'h7FFFFFF0, 5'd1, 5'd2, 1'b0, 3'b000);
    step("rd r1 r2", 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, 3'b000);
    check("r1 direct", rs_n, 32'd36);
    check("r2 direct", rt_n, 32'h7FFFFFF0);
    step("w r31", 1'b1, 5'd31, 32'd1, 5'd31, 5'd30, 1'b0, 3'b000);
    check("r31 direct", rs_n, 32'd1);
    check("r30 direct", rt_n, 32'd0);

    // randomized traffic, including X data with the write disabled
    for (int k = 0; k < 400; k++) begin
      logic        we, fwe;
      logic [4:0]  rd, rs, rt;
      logic [31:0] d;
      we  = 1'($urandom_range(0, 1));
      fwe = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      rs  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rt  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      d   = 32'($urandom);
      if (!we && $urandom_range(0, 3) == 0) d = 32'bx;
      step("random", we, rd, d, rs, rt, fwe, 3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
